// File: rtl/memory_write_controller.sv
// memory_write_controller
//   Turns a pipeline write request into one or three element writes to a
//   16-bit memory port. The request's row/column address is mapped to a linear
//   base address; a triple write walks horizontally (+1) or vertically
//   (+ROW_STRIDE) from the base, with silent 16-bit wrap.
//
// Ports
//   CLK        system clock, all state changes on its rising edge
//   RESET_N    asynchronous active-low reset
//   CLK_MEM    memory tick qualifier; state only advances on ticks
//              (abort and reset excepted)
//   ENABLE     level write request
//   Ctrl       [0]=0 single, [0]=1 triple; [1]=0 horizontal, [1]=1 vertical
//   ADDRESS    [31:16] row, [15:0] column
//   WRITE      element k in WRITE[16k+15:16k]
//   AddressMem registered memory address
//   WriteMem   registered memory write data
//   WE_MEM     registered memory write enable
//   HANDSHAKE  registered write-complete flag
//   BUSY       high whenever the controller is not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a tick with ENABLE=1
// W0    | driving element 0
// W1    | driving element 1 (triple only)
// W2    | driving element 2 (triple only)
// DONE  | HANDSHAKE high until a tick with ENABLE=0
module memory_write_controller #(
   parameter logic [15:0] ROW_STRIDE = 16'd256
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        CLK_MEM,
   input  logic        ENABLE,
   input  logic [1:0]  Ctrl,
   input  logic [31:0] ADDRESS,
   input  logic [47:0] WRITE,
   output logic [15:0] AddressMem,
   output logic [15:0] WriteMem,
   output logic        WE_MEM,
   output logic        HANDSHAKE,
   output logic        BUSY
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_W0   = 3'd1;
   localparam logic [2:0] S_W1   = 3'd2;
   localparam logic [2:0] S_W2   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]  state;
   logic [1:0]  cap_ctrl;
   logic [15:0] cap_base;
   // Element 0 goes straight to WriteMem on acceptance, so only 1 and 2 are kept.
   logic [31:0] cap_data;

   logic [15:0] in_base;
   logic [15:0] step;
   logic [15:0] addr_1;
   logic [15:0] addr_2;

   assign in_base = ADDRESS[31:16] * ROW_STRIDE + ADDRESS[15:0];
   assign step    = cap_ctrl[1] ? ROW_STRIDE : 16'd1;
   assign addr_1  = cap_base + step;
   assign addr_2  = cap_base + (step << 1);
   assign BUSY    = (state != S_IDLE);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= S_IDLE;
         cap_ctrl   <= 2'b00;
         cap_base   <= 16'h0000;
         cap_data   <= 32'h0;
         AddressMem <= 16'h0000;
         WriteMem   <= 16'h0000;
         WE_MEM     <= 1'b0;
         HANDSHAKE  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (CLK_MEM && ENABLE) begin
                  state      <= S_W0;
                  cap_ctrl   <= Ctrl;
                  cap_base   <= in_base;
                  cap_data   <= WRITE[47:16];
                  AddressMem <= in_base;
                  WriteMem   <= WRITE[15:0];
                  WE_MEM     <= 1'b1;
               end
            end
            S_W0, S_W1, S_W2: begin
               // Abort is checked on every CLK edge, not just on ticks.
               if (!ENABLE) begin
                  state  <= S_IDLE;
                  WE_MEM <= 1'b0;
               end else if (CLK_MEM) begin
                  if (state == S_W0 && cap_ctrl[0]) begin
                     state      <= S_W1;
                     AddressMem <= addr_1;
                     WriteMem   <= cap_data[15:0];
                  end else if (state == S_W1) begin
                     state      <= S_W2;
                     AddressMem <= addr_2;
                     WriteMem   <= cap_data[31:16];
                  end else begin
                     state     <= S_DONE;
                     WE_MEM    <= 1'b0;
                     HANDSHAKE <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (CLK_MEM && !ENABLE) begin
                  state     <= S_IDLE;
                  HANDSHAKE <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               WE_MEM    <= 1'b0;
               HANDSHAKE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_write_controller.sv
module tb_memory_write_controller;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        CLK_MEM;
   logic        ENABLE;
   logic [1:0]  Ctrl;
   logic [31:0] ADDRESS;
   logic [47:0] WRITE;
   logic [15:0] AddressMem;
   logic [15:0] WriteMem;
   logic        WE_MEM;
   logic        HANDSHAKE;
   logic        BUSY;

   int checks   = 0;
   int failures = 0;

   // Memory model: a write commits on a tick edge while WE_MEM is high.
   logic [15:0] log_addr [0:63];
   logic [15:0] log_data [0:63];
   int          log_n = 0;
   int          mark;

   memory_write_controller #(.ROW_STRIDE(16'd256)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CLK_MEM(CLK_MEM), .ENABLE(ENABLE),
      .Ctrl(Ctrl), .ADDRESS(ADDRESS), .WRITE(WRITE),
      .AddressMem(AddressMem), .WriteMem(WriteMem), .WE_MEM(WE_MEM),
      .HANDSHAKE(HANDSHAKE), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (CLK_MEM === 1'b1 && WE_MEM === 1'b1 && log_n < 64) begin
         log_addr[log_n] = AddressMem;
         log_data[log_n] = WriteMem;
         log_n = log_n + 1;
      end
   end

   task automatic step(input logic mem);
      CLK_MEM = mem;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0; CLK_MEM = 1'b1; ENABLE = 1'b1;
      Ctrl = 2'b00; ADDRESS = 32'h0001_0001; WRITE = 48'h1;
      #1;
      checks++;
      if ({WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem} !== 35'h0) begin
         failures++;
         $display("FAIL reset_state got we=%b hs=%b busy=%b a=%h d=%h want all zero",
                  WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem);
      end
      step(1'b1);
      checks++;
      if (BUSY !== 1'b0 || WE_MEM !== 1'b0) begin
         failures++;
         $display("FAIL reset_held got busy=%b we=%b want 0 0", BUSY, WE_MEM);
      end
      ENABLE = 1'b0;
      RESET_N = 1'b1;
      step(1'b1);
      checks++;
      if (BUSY !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_accept got busy=%b want 0", BUSY);
      end
   endtask

   task automatic test_single;
      mark = log_n;
      Ctrl = 2'b00; ADDRESS = 32'h0002_0005; WRITE = 48'h0000_0000_BEEF; ENABLE = 1'b1;
      step(1'b1);
      checks++;
      if ({WE_MEM, BUSY, HANDSHAKE, AddressMem, WriteMem} !== {3'b110, 16'h0205, 16'hBEEF}) begin
         failures++;
         $display("FAIL single_w0 got we=%b busy=%b hs=%b a=%h d=%h want 1 1 0 0205 beef",
                  WE_MEM, BUSY, HANDSHAKE, AddressMem, WriteMem);
      end
      ADDRESS = 32'h0009_0009; WRITE = 48'h0;
      step(1'b1);
      checks++;
      if ({WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem} !== {3'b011, 16'h0205, 16'hBEEF}) begin
         failures++;
         $display("FAIL single_done got we=%b hs=%b busy=%b a=%h d=%h want 0 1 1 0205 beef",
                  WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem);
      end
      ENABLE = 1'b0;
      step(1'b1);
      checks++;
      if (HANDSHAKE !== 1'b0 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got hs=%b busy=%b want 0 0", HANDSHAKE, BUSY);
      end
      checks++;
      if (log_n - mark != 1 || log_addr[mark] !== 16'h0205 || log_data[mark] !== 16'hBEEF) begin
         failures++;
         $display("FAIL single_commit got n=%0d a=%h d=%h want 1 0205 beef",
                  log_n - mark, log_addr[mark], log_data[mark]);
      end
   endtask

   task automatic run_triple(input string name, input logic [1:0] c, input logic [31:0] a,
                             input logic [47:0] w, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2);
      logic [15:0] ea [0:2];
      ea[0] = e0; ea[1] = e1; ea[2] = e2;
      mark = log_n;
      Ctrl = c; ADDRESS = a; WRITE = w; ENABLE = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b1);
         if (k == 0) begin ADDRESS = ~a; WRITE = ~w; Ctrl = ~c; end
         checks++;
         if (WE_MEM !== 1'b1 || HANDSHAKE !== 1'b0 || AddressMem !== ea[k] ||
             WriteMem !== w[16*k +: 16]) begin
            failures++;
            $display("FAIL %s_w%0d got we=%b hs=%b a=%h d=%h want 1 0 %h %h", name, k,
                     WE_MEM, HANDSHAKE, AddressMem, WriteMem, ea[k], w[16*k +: 16]);
         end
      end
      step(1'b1);
      checks++;
      if (HANDSHAKE !== 1'b1 || WE_MEM !== 1'b0 || AddressMem !== e2) begin
         failures++;
         $display("FAIL %s_done got hs=%b we=%b a=%h want 1 0 %h", name, HANDSHAKE, WE_MEM,
                  AddressMem, e2);
      end
      checks++;
      if (log_n - mark != 3 || log_addr[mark] !== e0 || log_addr[mark+1] !== e1 ||
          log_addr[mark+2] !== e2) begin
         failures++;
         $display("FAIL %s_commit got n=%0d a=%h,%h,%h want 3 %h,%h,%h", name, log_n - mark,
                  log_addr[mark], log_addr[mark+1], log_addr[mark+2], e0, e1, e2);
      end
      ENABLE = 1'b0;
      step(1'b1);
   endtask

   task automatic test_horizontal;
      run_triple("horiz", 2'b01, 32'h0001_00FF, 48'h3333_2222_1111,
                 16'h01FF, 16'h0200, 16'h0201);
   endtask

   task automatic test_vertical;
      run_triple("vert", 2'b11, 32'h00FF_0010, 48'hCCCC_BBBB_AAAA,
                 16'hFF10, 16'h0010, 16'h0110);
   endtask

   task automatic test_abort;
      mark = log_n;
      Ctrl = 2'b01; ADDRESS = 32'h0000_0040; WRITE = 48'h0303_0202_0101; ENABLE = 1'b1;
      step(1'b1);
      step(1'b1);
      ENABLE = 1'b0;
      step(1'b0);
      checks++;
      if (WE_MEM !== 1'b0 || HANDSHAKE !== 1'b0 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL abort_state got we=%b hs=%b busy=%b want 0 0 0", WE_MEM, HANDSHAKE, BUSY);
      end
      step(1'b1);
      step(1'b1);
      checks++;
      if (HANDSHAKE !== 1'b0 || log_n - mark != 1 || log_addr[mark] !== 16'h0040 ||
          log_data[mark] !== 16'h0101) begin
         failures++;
         $display("FAIL abort_commit got hs=%b n=%0d a=%h d=%h want 0 1 0040 0101",
                  HANDSHAKE, log_n - mark, log_addr[mark], log_data[mark]);
      end
   endtask

   task automatic test_reset_mid;
      mark = log_n;
      Ctrl = 2'b01; ADDRESS = 32'h0000_0010; WRITE = 48'h0C0C_0B0B_0A0A; ENABLE = 1'b1;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      checks++;
      if (WE_MEM !== 1'b1 || AddressMem !== 16'h0012) begin
         failures++;
         $display("FAIL rstmid_w2 got we=%b a=%h want 1 0012", WE_MEM, AddressMem);
      end
      #2 RESET_N = 1'b0; ENABLE = 1'b0;
      #1;
      checks++;
      if ({WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem} !== 35'h0) begin
         failures++;
         $display("FAIL rstmid_async got we=%b hs=%b busy=%b a=%h d=%h want all zero",
                  WE_MEM, HANDSHAKE, BUSY, AddressMem, WriteMem);
      end
      step(1'b1);
      RESET_N = 1'b1;
      checks++;
      if (log_n - mark != 2 || log_addr[mark+1] !== 16'h0011) begin
         failures++;
         $display("FAIL rstmid_commit got n=%0d a1=%h want 2 0011", log_n - mark,
                  log_addr[mark+1]);
      end
      Ctrl = 2'b00; ADDRESS = 32'h0000_0003; WRITE = 48'h0000_0000_5A5A; ENABLE = 1'b1;
      step(1'b1);
      step(1'b1);
      checks++;
      if (HANDSHAKE !== 1'b1 || AddressMem !== 16'h0003 || WriteMem !== 16'h5A5A) begin
         failures++;
         $display("FAIL rstmid_after got hs=%b a=%h d=%h want 1 0003 5a5a", HANDSHAKE,
                  AddressMem, WriteMem);
      end
      ENABLE = 1'b0;
      step(1'b1);
   endtask

   task automatic test_back_to_back;
      int bad;
      mark = log_n;
      Ctrl = 2'b00; ADDRESS = 32'h0003_0001; WRITE = 48'h0000_0000_1234; ENABLE = 1'b1;
      step(1'b1);
      bad = 0;
      for (int i = 1; i < 4; i++) begin
         step(1'b0);
         if (WE_MEM !== 1'b1 || AddressMem !== 16'h0301 || WriteMem !== 16'h1234) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL gate_stable got %0d unstable cycles want 0", bad);
      end
      step(1'b1);
      checks++;
      if (HANDSHAKE !== 1'b1 || WE_MEM !== 1'b0) begin
         failures++;
         $display("FAIL gate_done got hs=%b we=%b want 1 0", HANDSHAKE, WE_MEM);
      end
      ADDRESS = 32'h0004_0004;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step(i % 4 == 3);
         if (HANDSHAKE !== 1'b1 || BUSY !== 1'b1 || WE_MEM !== 1'b0 || AddressMem !== 16'h0301)
            bad++;
      end
      checks++;
      if (bad != 0 || log_n - mark != 1) begin
         failures++;
         $display("FAIL b2b_hold got %0d bad cycles, %0d commits want 0 1", bad, log_n - mark);
      end
      ENABLE = 1'b0;
      step(1'b0);
      checks++;
      if (HANDSHAKE !== 1'b1) begin
         failures++;
         $display("FAIL b2b_wait_tick got hs=%b want 1", HANDSHAKE);
      end
      step(1'b1);
      ENABLE = 1'b1;
      step(1'b0);
      checks++;
      if (HANDSHAKE !== 1'b0 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL b2b_release got hs=%b busy=%b want 0 0", HANDSHAKE, BUSY);
      end
      step(1'b1);
      checks++;
      if (WE_MEM !== 1'b1 || AddressMem !== 16'h0404) begin
         failures++;
         $display("FAIL b2b_reaccept got we=%b a=%h want 1 0404", WE_MEM, AddressMem);
      end
      ENABLE = 1'b0;
      step(1'b1);
   endtask

   initial begin
      test_reset;
      test_single;
      test_horizontal;
      test_vertical;
      test_abort;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
